kanade_mem_arbiter: RTL and testbench

KANADE_MEM_ARBITER -- requirements
Module: kanade_mem_arbiter

---
 rtl/kanade_pkg.sv | 26 ++
 rtl/kanade_load_align.sv | 43 ++++
 rtl/kanade_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_kanade_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/kanade_pkg.sv
// Shared definitions for the kanade memory path: access-mode encodings and the
// alignment rule used by both the request and response sides of the arbiter.
package kanade_pkg;

    localparam int unsigned ModeW = 3;

    typedef enum logic [ModeW-1:0] {
        ModeWord      = 3'd0,
        ModeByte      = 3'd1,
        ModeByteSign  = 3'd2,
        ModeHword     = 3'd3,
        ModeHwordSign = 3'd4
    } mode_e;

    // Codes 5..7 fall into the default arm and are handled as WORD.
    function automatic logic is_misaligned(logic [ModeW-1:0] mode, logic [1:0] off);
        logic mis;
        case (mode)
            ModeByte, ModeByteSign:   mis = 1'b0;
            ModeHword, ModeHwordSign: mis = off[0];
            default:                  mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/kanade_load_align.sv
// Load extraction: picks the byte/half-word addressed by offset out of a RAM
// word and zero- or sign-extends it; WORD and undefined codes pass through.
module kanade_load_align
    import kanade_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        offset,
    input  logic [ModeW-1:0]  mode,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;

    assign byte_sh = data >> {offset, 3'b000};
    assign half_sh = data >> {offset[1], 4'b0000};

    always_comb begin
        result = data;
        case (mode)
            ModeByte: begin
                result      = '0;
                result[7:0] = byte_sh[7:0];
            end
            ModeByteSign: begin
                result      = {DATA_W{byte_sh[7]}};
                result[7:0] = byte_sh[7:0];
            end
            ModeHword: begin
                result       = '0;
                result[15:0] = half_sh[15:0];
            end
            ModeHwordSign: begin
                result       = {DATA_W{half_sh[15]}};
                result[15:0] = half_sh[15:0];
            end
            default: result = data;
        endcase
    end

endmodule

// File: rtl/kanade_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between N_PORTS requesters,
// with store lane steering and a one-cycle registered load response.
module kanade_mem_arbiter
    import kanade_pkg::*;
#(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          req,
    input  logic [N_PORTS-1:0]          we,
    input  logic [N_PORTS*ADDR_W-1:0]   addr,
    input  logic [N_PORTS*ModeW-1:0]    mode,
    input  logic [N_PORTS*DATA_W-1:0]   wdata,
    output logic [N_PORTS-1:0]          gnt,
    output logic [N_PORTS-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic [N_PORTS-1:0]          misalign,
    output logic [ADDR_W-3:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    output logic [DATA_W/8-1:0]         ram_byteen,
    output logic                        ram_wren,
    input  logic [DATA_W-1:0]           ram_q
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned IdxW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [IdxW-1:0]   ptr_q;
    logic              rsp_valid_q;
    logic [IdxW-1:0]   rsp_idx_q;
    logic [1:0]        rsp_off_q;
    logic [ModeW-1:0]  rsp_mode_q;
    logic              rsp_we_q;
    logic [ADDR_W-3:0] ram_addr_q;

    logic              gnt_found;
    logic              gnt_v;
    logic [IdxW-1:0]   gnt_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [ModeW-1:0]  sel_mode;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_mis;
    logic [DATA_W-1:0] byte_data;
    logic [DATA_W-1:0] half_data;
    logic              rsp_live;
    logic              rsp_mis;
    logic [DATA_W-1:0] load_data;

    function automatic logic [IdxW-1:0] wrap_inc(logic [IdxW-1:0] base, int unsigned step);
        int unsigned k;
        k = 32'(base) + step;
        if (k >= N_PORTS) k = k - N_PORTS;
        return k[IdxW-1:0];
    endfunction

    // First requester at or after the priority pointer wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!gnt_found && req[wrap_inc(ptr_q, 32'(i))]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_inc(ptr_q, 32'(i));
            end
        end
    end

    assign gnt_v     = gnt_found & ~reset;
    assign sel_addr  = addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_mode  = mode[gnt_idx*ModeW +: ModeW];
    assign sel_we    = we[gnt_idx];
    assign sel_wdata = wdata[gnt_idx*DATA_W +: DATA_W];
    assign sel_mis   = is_misaligned(sel_mode, sel_addr[1:0]);

    always_comb begin
        gnt = '0;
        if (gnt_v) gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        byte_data       = '0;
        byte_data[7:0]  = sel_wdata[7:0];
        half_data       = '0;
        half_data[15:0] = sel_wdata[15:0];
    end

    always_comb begin
        ram_wren   = gnt_v & sel_we & ~sel_mis;
        ram_byteen = '1;
        ram_wdata  = '0;
        if (reset) begin
            ram_addr = '0;
        end else if (gnt_v) begin
            ram_addr = sel_addr[ADDR_W-1:2];
        end else begin
            ram_addr = ram_addr_q;
        end
        if (ram_wren) begin
            case (sel_mode)
                ModeByte, ModeByteSign: begin
                    ram_byteen = BE_W'(1) << sel_addr[1:0];
                    ram_wdata  = byte_data << {sel_addr[1:0], 3'b000};
                end
                ModeHword, ModeHwordSign: begin
                    ram_byteen = BE_W'(3) << {sel_addr[1], 1'b0};
                    ram_wdata  = half_data << {sel_addr[1], 4'b0000};
                end
                default: begin
                    ram_byteen = '1;
                    ram_wdata  = sel_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_off_q   <= 2'b00;
            rsp_mode_q  <= ModeWord;
            rsp_we_q    <= 1'b0;
            ram_addr_q  <= '0;
        end else begin
            rsp_valid_q <= gnt_v;
            if (gnt_v) begin
                ptr_q      <= wrap_inc(gnt_idx, 1);
                rsp_idx_q  <= gnt_idx;
                rsp_off_q  <= sel_addr[1:0];
                rsp_mode_q <= sel_mode;
                rsp_we_q   <= sel_we;
                ram_addr_q <= sel_addr[ADDR_W-1:2];
            end
        end
    end

    kanade_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .data   (ram_q),
        .offset (rsp_off_q),
        .mode   (rsp_mode_q),
        .result (load_data)
    );

    // Masking with reset drops a response whose grant came the cycle before reset.
    assign rsp_live = rsp_valid_q & ~reset;
    assign rsp_mis  = is_misaligned(rsp_mode_q, rsp_off_q);
    assign rdata    = (rsp_live && !rsp_we_q && !rsp_mis) ? load_data : '0;

    always_comb begin
        rvalid   = '0;
        misalign = '0;
        rvalid[rsp_idx_q]   = rsp_live;
        misalign[rsp_idx_q] = rsp_live & rsp_mis;
    end

endmodule

// File: tb/tb_kanade_mem_arbiter.sv
// Directed bench: a 2-port arbiter for access/lane/extension vectors and
// arbitration order, plus a 4-port instance for the wrap-around priority case.
module tb_kanade_mem_arbiter;

    localparam logic [2:0] MW = 3'd0, MB = 3'd1, MBS = 3'd2, MH = 3'd3, MHS = 3'd4;

    logic        clk;
    logic        reset;

    logic [1:0]  req2, we2, gnt2, rvalid2, misalign2;
    logic [63:0] addr2, wdata2;
    logic [5:0]  mode2;
    logic [31:0] rdata2, ram_wdata2, ram_q2;
    logic [29:0] ram_addr2;
    logic [3:0]  ram_byteen2;
    logic        ram_wren2;

    logic [3:0]   req4, we4, gnt4, rvalid4, misalign4;
    logic [127:0] addr4, wdata4;
    logic [11:0]  mode4;
    logic [31:0]  rdata4, ram_wdata4, ram_q4;
    logic [29:0]  ram_addr4;
    logic [3:0]   ram_byteen4;
    logic         ram_wren4;

    int n_checks = 0;
    int n_errors = 0;

    kanade_mem_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32)) u_dut2 (
        .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .mode(mode2),
        .wdata(wdata2), .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2),
        .misalign(misalign2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
        .ram_byteen(ram_byteen2), .ram_wren(ram_wren2), .ram_q(ram_q2)
    );

    kanade_mem_arbiter #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32)) u_dut4 (
        .clk(clk), .reset(reset), .req(req4), .we(we4), .addr(addr4), .mode(mode4),
        .wdata(wdata4), .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4),
        .misalign(misalign4), .ram_addr(ram_addr4), .ram_wdata(ram_wdata4),
        .ram_byteen(ram_byteen4), .ram_wren(ram_wren4), .ram_q(ram_q4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  mode;
        logic [31:0] wdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] ram_wd;
        logic [29:0] ram_a;
        logic [31:0] rdata;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input int p, input logic w, input logic [31:0] a, input logic [2:0] m,
                           input logic [31:0] wd, input logic mis, input logic [3:0] be,
                           input logic [31:0] rwd, input logic [29:0] ra, input logic [31:0] rd);
        vec_t v;
        v.port = p; v.we = w; v.addr = a; v.mode = m; v.wdata = wd; v.mis = mis;
        v.be = be; v.ram_wd = rwd; v.ram_a = ra; v.rdata = rd;
        vq.push_back(v);
    endtask

    task automatic drive2(input int p, input logic w, input logic [31:0] a, input logic [2:0] m,
                          input logic [31:0] wd);
        req2 = 2'b00;
        req2[p] = 1'b1;
        we2[p] = w;
        addr2[p*32 +: 32] = a;
        mode2[p*3 +: 3] = m;
        wdata2[p*32 +: 32] = wd;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        vec_t v;
        vec_t pv;

        reset = 1'b1;
        req2 = 2'b11; we2 = 2'b00; addr2 = '0; mode2 = '0; wdata2 = '0;
        ram_q2 = 32'h80FF7F01;
        req4 = 4'b0000; we4 = '0; addr4 = '0; mode4 = '0; wdata4 = '0; ram_q4 = '0;

        // Reset state, with both ports requesting.
        @(negedge clk); @(negedge clk);
        #1;
        check_eq("rst_gnt", 64'(gnt2), 64'h0);
        check_eq("rst_rvalid", 64'(rvalid2), 64'h0);
        check_eq("rst_misalign", 64'(misalign2), 64'h0);
        check_eq("rst_wren", 64'(ram_wren2), 64'h0);
        check_eq("rst_ram_addr", 64'(ram_addr2), 64'h0);
        check_eq("rst_ram_wdata", 64'(ram_wdata2), 64'h0);
        check_eq("rst_byteen", 64'(ram_byteen2), 64'hF);
        check_eq("rst_rdata", 64'(rdata2), 64'h0);

        // port, we, addr, mode, wdata, mis, byteen, ram_wdata, ram_addr, rdata
        add_vec(0, 1, 32'h103, MB,   32'hA5,       0, 4'b1000, 32'hA500_0000, 30'h40, 32'h0);
        add_vec(1, 0, 32'h2,   MBS,  32'h0,        0, 4'b1111, 32'h0,         30'h0,  32'hFFFF_FFFF);
        add_vec(1, 0, 32'h2,   MH,   32'h0,        0, 4'b1111, 32'h0,         30'h0,  32'h0000_80FF);
        add_vec(1, 0, 32'h2,   MHS,  32'h0,        0, 4'b1111, 32'h0,         30'h0,  32'hFFFF_80FF);
        add_vec(0, 0, 32'h1,   MBS,  32'h0,        0, 4'b1111, 32'h0,         30'h0,  32'h0000_007F);
        add_vec(0, 0, 32'h3,   MB,   32'h0,        0, 4'b1111, 32'h0,         30'h0,  32'h0000_0080);
        add_vec(1, 0, 32'h10,  MW,   32'h0,        0, 4'b1111, 32'h0,         30'h4,  32'h80FF_7F01);
        add_vec(0, 1, 32'h206, MH,   32'hBEEF,     0, 4'b1100, 32'hBEEF_0000, 30'h81, 32'h0);
        add_vec(1, 1, 32'h8,   MHS,  32'h1234,     0, 4'b0011, 32'h0000_1234, 30'h2,  32'h0);
        add_vec(0, 1, 32'h6,   MW,   32'hDEADBEEF, 1, 4'b1111, 32'h0,         30'h1,  32'h0);
        add_vec(1, 0, 32'h1,   MH,   32'h0,        1, 4'b1111, 32'h0,         30'h0,  32'h0);
        add_vec(0, 1, 32'hC,   3'd7, 32'hCAFEF00D, 0, 4'b1111, 32'hCAFE_F00D, 30'h3,  32'h0);
        add_vec(1, 0, 32'h0,   3'd5, 32'h0,        0, 4'b1111, 32'h0,         30'h0,  32'h80FF_7F01);
        add_vec(0, 1, 32'h11,  MB,   32'h5A,       0, 4'b0010, 32'h0000_5A00, 30'h4,  32'h0);

        // Back-to-back single-requester accesses; response of i-1 checked with request i.
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i <= vq.size(); i++) begin
            if (i > 0) @(negedge clk);
            if (i < vq.size()) begin
                v = vq[i];
                drive2(v.port, v.we, v.addr, v.mode, v.wdata);
            end else begin
                req2 = 2'b00;
            end
            #1;
            if (i < vq.size()) begin
                exp_g = (v.port == 0) ? 2'b01 : 2'b10;
                check_eq($sformatf("v%0d_gnt", i), 64'(gnt2), 64'(exp_g));
                check_eq($sformatf("v%0d_ram_addr", i), 64'(ram_addr2), 64'(v.ram_a));
                check_eq($sformatf("v%0d_wren", i), 64'(ram_wren2), 64'(v.we & ~v.mis));
                if (!v.mis) check_eq($sformatf("v%0d_byteen", i), 64'(ram_byteen2), 64'(v.be));
                if (v.we && !v.mis)
                    check_eq($sformatf("v%0d_ram_wdata", i), 64'(ram_wdata2), 64'(v.ram_wd));
            end else begin
                check_eq("idle_gnt", 64'(gnt2), 64'h0);
                check_eq("idle_wren", 64'(ram_wren2), 64'h0);
                check_eq("idle_ram_addr_hold", 64'(ram_addr2), 64'h4);
            end
            if (i > 0) begin
                pv = vq[i-1];
                exp_g = (pv.port == 0) ? 2'b01 : 2'b10;
                check_eq($sformatf("v%0d_rvalid", i-1), 64'(rvalid2), 64'(exp_g));
                check_eq($sformatf("v%0d_misalign", i-1), 64'(misalign2),
                         pv.mis ? 64'(exp_g) : 64'h0);
                check_eq($sformatf("v%0d_rdata", i-1), 64'(rdata2), 64'(pv.rdata));
            end
        end
        @(negedge clk); #1;
        check_eq("idle_rvalid", 64'(rvalid2), 64'h0);
        check_eq("idle_rdata", 64'(rdata2), 64'h0);

        // Both ports requesting continuously after reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive2(0, 0, 32'h0, MW, 32'h0);
        drive2(1, 0, 32'h4, MW, 32'h0);
        prev_g = 2'b00;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk);
            req2 = (k < 6) ? 2'b11 : 2'b00;
            #1;
            exp_g = (k >= 6) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            check_eq($sformatf("rr%0d_gnt", k), 64'(gnt2), 64'(exp_g));
            if (k > 0) begin
                check_eq($sformatf("rr%0d_rvalid", k), 64'(rvalid2), 64'(prev_g));
                check_eq($sformatf("rr%0d_rdata", k), 64'(rdata2), 64'h80FF_7F01);
            end
            prev_g = exp_g;
        end

        // Reset the cycle after a load grant: the response is dropped, pointer returns to 0.
        @(negedge clk);
        drive2(1, 0, 32'h8, MW, 32'h0);
        #1;
        check_eq("rg_gnt", 64'(gnt2), 64'h2);
        @(negedge clk);
        reset = 1'b1;
        req2 = 2'b11;
        #1;
        check_eq("rg_rst_rvalid", 64'(rvalid2), 64'h0);
        check_eq("rg_rst_gnt", 64'(gnt2), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rg_post_gnt", 64'(gnt2), 64'h1);
        check_eq("rg_post_rvalid", 64'(rvalid2), 64'h0);
        @(negedge clk);
        req2 = 2'b00;
        #1;
        check_eq("rg_post_rsp", 64'(rvalid2), 64'h1);

        // Four ports: after port 1, port 3 precedes the wrap back to port 1.
        @(negedge clk);
        addr4[3*32 +: 32] = 32'h30;
        addr4[1*32 +: 32] = 32'h14;
        req4 = 4'b0010;
        #1;
        check_eq("p4_first_gnt", 64'(gnt4), 64'h2);
        @(negedge clk);
        req4 = 4'b1010;
        #1;
        check_eq("p4_gnt_port3", 64'(gnt4), 64'h8);
        check_eq("p4_ram_addr3", 64'(ram_addr4), 64'hC);
        check_eq("p4_rvalid1", 64'(rvalid4), 64'h2);
        @(negedge clk);
        #1;
        check_eq("p4_gnt_port1", 64'(gnt4), 64'h2);
        check_eq("p4_rvalid3", 64'(rvalid4), 64'h8);
        @(negedge clk);
        req4 = 4'b0000;
        #1;
        check_eq("p4_idle_gnt", 64'(gnt4), 64'h0);
        check_eq("p4_rvalid1b", 64'(rvalid4), 64'h2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
